// File: rtl/lut_conf_loader.sv
// lut_conf_loader: streaming configuration loader for the piecewise-linear LUT cores.
// While conf_mode is high, a load is one header word (target channel in bits
// [CH_BITS-1:0]) followed by LUT_DEPTH (base, slope) pairs. Each accepted slope
// word produces one write to the selected table. A sticky per-channel flag
// records which tables hold a complete load.
//
// Optional feature (macro LUT_CONF_CHECKSUM_EN): one trailing word must equal the
// DATA_W-bit wrap-around sum of all base and slope words in the load. Otherwise
// the load is rejected.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   conf_mode         level; a rising edge starts a load, a low level aborts one
//   din_valid/din     stream word and its valid
//   din_ready         loader accepts din this cycle
//   conf_wr_ready     the selected LUT core can take a write
//   conf_wr_en        one-hot write strobe (combinational)
//   conf_addr         write address (entry pointer)
//   conf_data_base    held base word
//   conf_data_slope   current din
//   conf_done         pulse when a load completes successfully
//   conf_err          pulse on a bad header, an abort or a checksum failure
//   configured        sticky per-channel loaded flags
//   state_dbg         current state encoding
module lut_conf_loader #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SEG_BITS  = 8,
  parameter int unsigned LUT_DEPTH = 256,
  parameter int unsigned N_LUT     = 4,
  parameter int unsigned CH_BITS   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                conf_mode,
  input  logic                din_valid,
  input  logic [DATA_W-1:0]   din,
  output logic                din_ready,
  input  logic                conf_wr_ready,
  output logic [N_LUT-1:0]    conf_wr_en,
  output logic [SEG_BITS-1:0] conf_addr,
  output logic [DATA_W-1:0]   conf_data_base,
  output logic [DATA_W-1:0]   conf_data_slope,
  output logic                conf_done,
  output logic                conf_err,
  output logic [N_LUT-1:0]    configured,
  output logic [2:0]          state_dbg
);

  localparam logic [SEG_BITS-1:0] LAST_PTR = SEG_BITS'(LUT_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    GET_B = 3'd2,
`ifdef LUT_CONF_CHECKSUM_EN
    GET_S = 3'd3,
    CHK   = 3'd4
`else
    GET_S = 3'd3
`endif
  } state_t;

  state_t              st;
  state_t              st_nxt;
  logic [SEG_BITS-1:0] ptr;
  logic [DATA_W-1:0]   base_hold;
  logic [CH_BITS-1:0]  ch;
  logic                conf_mode_d;

  logic                rise;
  logic                abort;
  logic                acc;
  logic [CH_BITS-1:0]  hdr_ch;
  logic                hdr_ok;
  logic                wr_fire;
  logic                last_wr;

`ifdef LUT_CONF_CHECKSUM_EN
  logic [DATA_W-1:0]   sum;
  logic                sum_ok;
  assign sum_ok = (din == sum);
`endif

  // Handshake and event decode; abort overrides any acceptance.
  assign rise      = conf_mode & ~conf_mode_d;
  assign abort     = (st != IDLE) & ~conf_mode;
  assign din_ready = (st == GET_S) ? conf_wr_ready : (st != IDLE);
  assign acc       = din_valid & din_ready;
  assign hdr_ch    = din[CH_BITS-1:0];
  assign hdr_ok    = 32'(hdr_ch) < N_LUT;
  assign wr_fire   = (st == GET_S) & acc & ~abort;
  assign last_wr   = wr_fire & (ptr == LAST_PTR);

  assign conf_addr       = ptr;
  assign conf_data_base  = base_hold;
  assign conf_data_slope = din;
  assign state_dbg       = st;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    if (abort) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:  if (rise) st_nxt = HDR;
        HDR:   if (acc) st_nxt = hdr_ok ? GET_B : IDLE;
        GET_B: if (acc) st_nxt = GET_S;
        GET_S: begin
          if (acc) begin
`ifdef LUT_CONF_CHECKSUM_EN
            st_nxt = (ptr == LAST_PTR) ? CHK : GET_B;
`else
            st_nxt = (ptr == LAST_PTR) ? IDLE : GET_B;
`endif
          end
        end
`ifdef LUT_CONF_CHECKSUM_EN
        CHK:   if (acc) st_nxt = IDLE;
`endif
        default: st_nxt = IDLE;
      endcase
    end
  end

  // Output logic: Mealy write strobe and status pulses.
  always_comb begin
    conf_wr_en = '0;
    conf_done  = 1'b0;
    conf_err   = abort;
    for (int i = 0; i < int'(N_LUT); i++) begin
      conf_wr_en[i] = wr_fire & (ch == CH_BITS'(i));
    end
    if (!abort) begin
      if (st == HDR && acc && !hdr_ok) conf_err = 1'b1;
`ifdef LUT_CONF_CHECKSUM_EN
      if (st == CHK && acc) begin
        conf_done = sum_ok;
        conf_err  = ~sum_ok;
      end
`else
      conf_done = last_wr;
`endif
    end
  end

  // Load datapath: pointer, held base, channel select and edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      base_hold   <= '0;
      ch          <= '0;
      conf_mode_d <= 1'b0;
    end else begin
      conf_mode_d <= conf_mode;
      if (st == IDLE && rise) begin
        ptr       <= '0;
        base_hold <= '0;
      end
      if (!abort) begin
        if (st == HDR && acc)   ch        <= hdr_ch;
        if (st == GET_B && acc) base_hold <= din;
        if (wr_fire && !last_wr) ptr      <= ptr + SEG_BITS'(1);
      end
    end
  end

`ifdef LUT_CONF_CHECKSUM_EN
  // Running sum of every base and slope word in the current load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (st == IDLE && rise) begin
      sum <= '0;
    end else if (!abort && acc && (st == GET_B || st == GET_S)) begin
      sum <= sum + din;
    end
  end
`endif

  // Sticky flags: cleared when a valid header targets the channel, set on done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      configured <= '0;
    end else begin
      for (int i = 0; i < int'(N_LUT); i++) begin
        if (st == HDR && acc && !abort && hdr_ok && hdr_ch == CH_BITS'(i)) begin
          configured[i] <= 1'b0;
        end else if (conf_done && ch == CH_BITS'(i)) begin
          configured[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_conf_loader.sv
// tb_lut_conf_loader: directed bench for lut_conf_loader with N_LUT=4,
// LUT_DEPTH=4, CH_BITS=3. Inputs change on the falling edge. Outputs are sampled
// 1 ns later, so the combinational write strobe can be seen in its write cycle.
module tb_lut_conf_loader;

  logic        clk;
  logic        rst_n;
  logic        conf_mode;
  logic        din_valid;
  logic [15:0] din;
  logic        din_ready;
  logic        conf_wr_ready;
  logic [3:0]  conf_wr_en;
  logic [7:0]  conf_addr;
  logic [15:0] conf_data_base;
  logic [15:0] conf_data_slope;
  logic        conf_done;
  logic        conf_err;
  logic [3:0]  configured;
  logic [2:0]  state_dbg;

  lut_conf_loader #(
    .DATA_W(16), .SEG_BITS(8), .LUT_DEPTH(4), .N_LUT(4), .CH_BITS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .conf_mode(conf_mode),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .conf_wr_ready(conf_wr_ready), .conf_wr_en(conf_wr_en),
    .conf_addr(conf_addr), .conf_data_base(conf_data_base),
    .conf_data_slope(conf_data_slope), .conf_done(conf_done),
    .conf_err(conf_err), .configured(configured), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LUT_CONF_CHECKSUM_EN
  localparam logic DONE_ON_LAST_WR = 1'b0;
`else
  localparam logic DONE_ON_LAST_WR = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  // Write log and per-cycle snapshots.
  logic [3:0]  lg_en[$];
  logic [7:0]  lg_addr[$];
  logic [15:0] lg_base[$];
  logic [15:0] lg_slope[$];
  logic        lg_done[$];
  int          done_cnt;
  int          err_cnt;
  logic        s_ready;
  logic        s_err;
  logic [3:0]  s_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    lg_en.delete(); lg_addr.delete(); lg_base.delete();
    lg_slope.delete(); lg_done.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // One cycle of stimulus. Outputs are snapshotted and logged mid-cycle.
  task automatic drive(input logic v, input logic [15:0] d, input logic wr_rdy,
                       output logic accepted);
    @(negedge clk);
    din_valid     = v;
    din           = d;
    conf_wr_ready = wr_rdy;
    #1;
    s_ready = din_ready;
    s_err   = conf_err;
    s_wr    = conf_wr_en;
    if (conf_wr_en != 4'b0000) begin
      lg_en.push_back(conf_wr_en);
      lg_addr.push_back(conf_addr);
      lg_base.push_back(conf_data_base);
      lg_slope.push_back(conf_data_slope);
      lg_done.push_back(conf_done);
    end
    if (conf_done) done_cnt++;
    if (conf_err)  err_cnt++;
    accepted = v & din_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d);
    logic a;
    a = 1'b0;
    for (int n = 0; n < 16 && !a; n++) drive(1'b1, d, 1'b1, a);
    if (!a) check("accept_timeout", 32'(a), 32'd1);
  endtask

  task automatic idle();
    logic a;
    drive(1'b0, 16'd0, 1'b1, a);
  endtask

  // Drop conf_mode for one cycle, then raise it; the loader ends up in HDR.
  task automatic start_load();
    @(negedge clk);
    conf_mode = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    conf_mode = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Send four pairs base=b0+db*i, slope=s0+ds*i, with optional ready stalls
  // before the slope of entry stall_idx. With the checksum, the trailing word
  // is the sum plus adj.
  task automatic body(input int b0, input int db, input int s0, input int ds,
                      input int stall_idx, input int stall_n, input int adj);
    logic        a;
    logic [15:0] sum;
    sum = 16'd0;
    for (int i = 0; i < 4; i++) begin
      send_word(16'(b0 + db * i));
      sum = sum + 16'(b0 + db * i);
      if (i == stall_idx) begin
        for (int k = 0; k < stall_n; k++) begin
          drive(1'b1, 16'(s0 + ds * i), 1'b0, a);
          check("stall_ready", 32'(s_ready), 32'd0);
          check("stall_wr", 32'(s_wr), 32'd0);
        end
      end
      send_word(16'(s0 + ds * i));
      sum = sum + 16'(s0 + ds * i);
    end
`ifdef LUT_CONF_CHECKSUM_EN
    send_word(sum + 16'(adj));
`else
    if (adj != 0) $display("note: adj %0d unused, sum %0d", adj, sum);
`endif
    idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    rst_n = 1'b0; conf_mode = 1'b0; din_valid = 1'b0; din = 16'd0; conf_wr_ready = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd0);
    check("rst_wr", 32'(conf_wr_en), 32'd0);
    check("rst_done", 32'(conf_done), 32'd0);
    check("rst_err", 32'(conf_err), 32'd0);
    check("rst_cfg", 32'(configured), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load of channel 2.
    clr();
    start_load();
    check("t1_hdr_state", 32'(state_dbg), 32'd1);
    send_word(16'd2);
    body(10, 10, 1, 1, -1, 0, 0);
    check("t1_nwr", 32'(lg_en.size()), 32'd4);
    for (int i = 0; i < 4 && i < lg_en.size(); i++) begin
      check("t1_en", 32'(lg_en[i]), 32'b0100);
      check("t1_addr", 32'(lg_addr[i]), 32'(i));
      check("t1_base", 32'(lg_base[i]), 32'(10 * (i + 1)));
      check("t1_slope", 32'(lg_slope[i]), 32'(i + 1));
    end
    if (lg_done.size() == 4) begin
      check("t1_done_first", 32'(lg_done[0]), 32'd0);
      check("t1_done_last", 32'(lg_done[3]), 32'(DONE_ON_LAST_WR));
    end
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);
    check("t1_cfg", 32'(configured), 32'b0100);
    check("t1_idle", 32'(state_dbg), 32'd0);

    // Channel 0 then channel 3 after reset; then reload channel 0.
    @(negedge clk); rst_n = 1'b0; conf_mode = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    clr();
    start_load(); send_word(16'd0); body(100, 1, 200, 1, -1, 0, 0);
    start_load(); send_word(16'd3); body(300, 1, 400, 1, -1, 0, 0);
    check("t2_cfg", 32'(configured), 32'b1001);
    start_load(); send_word(16'd0);
    check("t2_cfg_cleared", 32'(configured), 32'b1000);
    body(500, 1, 600, 1, -1, 0, 0);
    check("t2_cfg_reload", 32'(configured), 32'b1001);
    check("t2_done_cnt", 32'(done_cnt), 32'd3);

    // Out-of-range header.
    clr();
    start_load(); send_word(16'd5);
    check("t3_err_pulse", 32'(s_err), 32'd1);
    idle();
    check("t3_err_cnt", 32'(err_cnt), 32'd1);
    check("t3_nwr", 32'(lg_en.size()), 32'd0);
    check("t3_state", 32'(state_dbg), 32'd0);
    check("t3_cfg", 32'(configured), 32'b1001);

    // Write back-pressure during the slope of entry 1.
    clr();
    start_load(); send_word(16'd1); body(7, 1, 9, 1, 1, 3, 0);
    check("t4_nwr", 32'(lg_en.size()), 32'd4);
    n1 = 0;
    foreach (lg_addr[i]) if (lg_addr[i] == 8'd1) n1++;
    check("t4_entry1_writes", 32'(n1), 32'd1);
    check("t4_cfg", 32'(configured), 32'b1011);

    // Abort with a slope word pending in GET_S.
    clr();
    start_load(); send_word(16'd1);
    send_word(16'd11); send_word(16'd12);
    send_word(16'd21); send_word(16'd22);
    send_word(16'd31);
    begin
      logic a;
      conf_mode = 1'b0;
      drive(1'b1, 16'd32, 1'b1, a);
    end
    check("t5_abort_err", 32'(s_err), 32'd1);
    check("t5_abort_nowr", 32'(s_wr), 32'd0);
    check("t5_nwr", 32'(lg_en.size()), 32'd2);
    check("t5_state", 32'(state_dbg), 32'd0);
    check("t5_cfg", 32'(configured), 32'b1001);
    check("t5_err_cnt", 32'(err_cnt), 32'd1);

    // Reset in the middle of a load.
    start_load(); send_word(16'd3); send_word(16'd100);
    @(negedge clk);
    din_valid = 1'b1; din = 16'd55; rst_n = 1'b0;
    #1;
    check("t6_state", 32'(state_dbg), 32'd0);
    check("t6_ready", 32'(din_ready), 32'd0);
    check("t6_wr", 32'(conf_wr_en), 32'd0);
    check("t6_done", 32'(conf_done), 32'd0);
    check("t6_err", 32'(conf_err), 32'd0);
    check("t6_cfg", 32'(configured), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; conf_mode = 1'b0; din_valid = 1'b0;

`ifdef LUT_CONF_CHECKSUM_EN
    // Pairs (1,2)(3,4)(5,6)(7,8): correct checksum 36, then a wrong 35.
    clr();
    start_load(); send_word(16'd2); body(1, 2, 2, 2, -1, 0, 0);
    check("t7_done_cnt", 32'(done_cnt), 32'd1);
    check("t7_err_cnt", 32'(err_cnt), 32'd0);
    check("t7_cfg", 32'(configured), 32'b0100);
    clr();
    start_load(); send_word(16'd2); body(1, 2, 2, 2, -1, 0, -1);
    check("t7b_done_cnt", 32'(done_cnt), 32'd0);
    check("t7b_err_cnt", 32'(err_cnt), 32'd1);
    check("t7b_cfg", 32'(configured), 32'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
